// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// The optional STALL_PERF_CNT_EN performance counters use CNT_W as their width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [5:0] NOP_CTRL = 6'd63;
  localparam int         CNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset. When clr and inc arrive
// together the count restarts at 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] base;

  assign base = clr ? '0 : count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (base != '1))
      count <= base + 1'b1;
    else
      count <= base;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline write-enable / bubble control for the 5-stage core: 4-state FSM,
// stall watchdog, and optional perf counters under STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int         MAX_STALL = 3,
  parameter int         CNT_W     = pipe_ctrl_pkg::CNT_W,
  parameter logic [5:0] NOP_CTRL  = pipe_ctrl_pkg::NOP_CTRL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [5:0]       idex_ctrl_sel,
  output logic             stall_active,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  import pipe_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] MAX_STALL_W = CNT_W'(MAX_STALL);

  state_t           state, next_state;
  logic             stall_take;
  logic             wdog_clr;
  logic             err_set;
  logic [CNT_W-1:0] wdog;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_err <= 1'b0;
    end else begin
      state <= next_state;
      if (err_set)
        stall_err <= 1'b1;
    end
  end

  // Priority chain halt > branch > hazard; FLUSH masks hazard because ID holds a NOP.
  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_take  = 1'b0;
    next_state  = RUN;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (halt) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_bubble = 1'b1;
      next_state  = HALT;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      next_state  = FLUSH;
    end else if (hazard && (state != FLUSH)) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_bubble = 1'b1;
      stall_take  = 1'b1;
      next_state  = STALL;
    end
  end

  // The watchdog only keeps counting while a stall continues; a new stall restarts it at 1.
  assign wdog_clr      = !((state == STALL) && stall_take);
  assign err_set       = (state == STALL) && stall_take && (wdog >= MAX_STALL_W);
  assign stall_active  = (state == STALL) || stall_take;
  assign idex_ctrl_sel = idex_bubble ? NOP_CTRL : 6'd0;

  sat_counter #(.W(CNT_W)) u_wdog (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_take),
    .clr   (wdog_clr),
    .count (wdog)
  );

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_take),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush && !reset),
    .clr   (1'b0),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random
// traffic against a behavioural model of the stall/flush/halt rules.
module tb_pipeline_stall_ctrl;

  localparam int         MAX_STALL = 3;
  localparam int         CNT_W     = 16;
  localparam logic [5:0] NOP       = 6'd63;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_HALT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1, hazard = 1'b0, branch_taken = 1'b0, halt = 1'b0;
  logic             pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_active, stall_err;
  logic [5:0]       idex_ctrl_sel;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: mode, length of the current consecutive stall run, sticky error, event counts.
  int m_mode   = M_RUN;
  int m_run    = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;
  int m_flush  = 0;

  typedef struct {
    bit r, pc, ifw, fl, bub, sa, take, nerr;
    int nmode, nrun;
  } exp_t;

  exp_t e;

  pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W), .NOP_CTRL(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .halt          (halt),
    .pc_wen        (pc_wen),
    .ifid_wen      (ifid_wen),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .idex_ctrl_sel (idex_ctrl_sel),
    .stall_active  (stall_active),
    .stall_err     (stall_err),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input bit r, input bit hl, input bit b, input bit h);
    exp_t x;
    x.r = r; x.pc = 1; x.ifw = 1; x.fl = 0; x.bub = 0; x.take = 0;
    x.sa = (m_mode == M_STALL);
    x.nmode = M_RUN; x.nrun = 0; x.nerr = m_err;
    if (r) begin
      x.fl = 1; x.bub = 1; x.nerr = 0;
    end else if (hl) begin
      x.pc = 0; x.ifw = 0; x.bub = 1; x.nmode = M_HALT;
    end else if (b) begin
      x.fl = 1; x.bub = 1; x.nmode = M_FLUSH;
    end else if (h && m_mode != M_FLUSH) begin
      x.pc = 0; x.ifw = 0; x.bub = 1; x.take = 1; x.sa = 1; x.nmode = M_STALL;
      x.nrun = (m_mode == M_STALL) ? m_run + 1 : 1;
      if (x.nrun > MAX_STALL) x.nerr = 1;
    end
    return x;
  endfunction

  function automatic logic [42:0] exp_vec(input exp_t x);
    logic [CNT_W-1:0] s, f;
    s = PERF ? CNT_W'(m_stalls) : '0;
    f = PERF ? CNT_W'(m_flush) : '0;
    return {x.pc, x.ifw, x.fl, x.bub, (x.bub ? NOP : 6'd0), m_err, s, f};
  endfunction

  function automatic logic [42:0] obs_vec();
    return {pc_wen, ifid_wen, ifid_flush, idex_bubble, idex_ctrl_sel, stall_err,
            stall_cycles, flush_count};
  endfunction

  // Drive one cycle of inputs well after the falling edge, then settle before sampling.
  task automatic apply(input logic [3:0] s);
    {reset, halt, branch_taken, hazard} = s;
    #2;
    e = model(s[3], s[2], s[1], s[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = e.nmode;
    m_run  = e.nrun;
    m_err  = e.nerr;
    if (e.r) begin
      m_stalls = 0; m_flush = 0;
    end else begin
      m_stalls += int'(e.take);
      m_flush  += int'(e.fl);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(4'b1000);
    tick();
    apply(4'b1001);
    checks++;
    if ({pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_err} !== 5'b11110) begin
      errors++;
      $display("[TB] FAIL reset_outputs cyc %0d: got %b want 11110", cyc,
               {pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_err});
    end
    tick();
    apply(4'b0000);
    checks++;
    if (obs_vec() !== exp_vec(e)) begin
      errors++;
      $display("[TB] FAIL reset_release cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec(e));
    end
    tick();
  endtask

  task automatic test_single_hazard();
    logic [3:0] stim[$] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL single_hazard step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      checks++;
      if (stall_active !== e.sa) begin
        errors++;
        $display("[TB] FAIL single_hazard stall_active step %0d: got %b want %b", i, stall_active, e.sa);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] stim[$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL watchdog step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      checks++;
      if (stall_active !== e.sa) begin
        errors++;
        $display("[TB] FAIL watchdog stall_active step %0d: got %b want %b", i, stall_active, e.sa);
      end
      tick();
    end
    apply(4'b0000);
    checks++;
    if (stall_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL watchdog_sticky: got %b want 1", stall_err);
    end
    tick();
  endtask

  task automatic test_branch_hazard();
    logic [3:0] stim[$] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL branch_hazard step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      checks++;
      if (stall_active !== e.sa) begin
        errors++;
        $display("[TB] FAIL branch_hazard stall_active step %0d: got %b want %b", i, stall_active, e.sa);
      end
      tick();
    end
  endtask

  task automatic test_halt_in_stall();
    logic [3:0] stim[$] = '{4'b0001, 4'b0001, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL halt_in_stall step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      checks++;
      if (stall_active !== e.sa) begin
        errors++;
        $display("[TB] FAIL halt_in_stall stall_active step %0d: got %b want %b", i, stall_active, e.sa);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [3:0] stim[$] = '{4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL reset_mid_stall step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      if (!e.r) begin
        checks++;
        if (stall_active !== e.sa) begin
          errors++;
          $display("[TB] FAIL reset_mid_stall stall_active step %0d: got %b want %b", i, stall_active, e.sa);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim[$] = '{4'b0010, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      apply(stim[i]);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d: got %h want %h", i, obs_vec(), exp_vec(e));
      end
      checks++;
      if (stall_active !== e.sa) begin
        errors++;
        $display("[TB] FAIL back_to_back stall_active step %0d: got %b want %b", i, stall_active, e.sa);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    for (int i = 0; i < 400; i++) begin
      s[3] = ($urandom_range(0, 63) == 0);
      s[2] = ($urandom_range(0, 7) == 0);
      s[1] = ($urandom_range(0, 5) == 0);
      s[0] = ($urandom_range(0, 1) == 0);
      apply(s);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("[TB] FAIL random cyc %0d in %b: got %h want %h", cyc, s, obs_vec(), exp_vec(e));
      end
      if (!e.r) begin
        checks++;
        if (stall_active !== e.sa) begin
          errors++;
          $display("[TB] FAIL random stall_active cyc %0d: got %b want %b", cyc, stall_active, e.sa);
        end
      end
      tick();
    end
  endtask

  initial begin
    $display("[TB] start, perf counters %s", PERF ? "on" : "off");
    test_reset();
    test_single_hazard();
    test_watchdog();
    test_branch_hazard();
    test_halt_in_stall();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
